// File: rtl/ram_slot_scheduler.sv
// Shared-RAM slot scheduler: an 8-phase bus cycle alternates CPU and video slots,
// arbitrates the slot owner at each slot boundary and decodes RAM strobes per phase.
module ram_slot_scheduler #(
  parameter int unsigned REF_MAX = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk8_en_p,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic       vid_req,
  input  logic       snd_req,
  input  logic       refresh_tick,
  output logic [2:0] bus_phase,
  output logic       video_slot,
  output logic       grant_cpu,
  output logic       grant_vid,
  output logic       grant_snd,
  output logic       grant_ref,
  output logic       cpu_ack,
  output logic       ram_oe,
  output logic       ram_we,
  output logic [2:0] ref_pending
);

  localparam logic [2:0] REF_LIM = 3'(REF_MAX);

  logic       boundary;
  logic       we_l;
  logic       ref_take;
  logic [3:0] grant_nxt;  // {cpu, vid, snd, ref}

  // A tick that coincides with a granted refresh cancels it out; excess ticks at the limit are lost.
  function automatic logic [2:0] ref_next(input logic [2:0] cnt, input logic tick,
                                          input logic take);
    logic [2:0] res;
    res = cnt;
    if (take) begin
      if (!tick) res = cnt - 3'd1;
    end else if (tick && (cnt < REF_LIM)) begin
      res = cnt + 3'd1;
    end
    return res;
  endfunction

  always_comb begin
    boundary  = clk8_en_p && (bus_phase == 3'd7);
    grant_nxt = 4'b0000;
    if (!video_slot) begin
      // Entering a video slot: an idle slot is lent to the CPU as last resort.
      if (vid_req)                  grant_nxt = 4'b0100;
      else if (snd_req)             grant_nxt = 4'b0010;
      else if (ref_pending != 3'd0) grant_nxt = 4'b0001;
      else if (cpu_req)             grant_nxt = 4'b1000;
    end else begin
      if (cpu_req)                  grant_nxt = 4'b1000;
      else if (ref_pending != 3'd0) grant_nxt = 4'b0001;
    end
    ref_take = boundary && grant_nxt[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_phase   <= 3'd0;
      video_slot  <= 1'b0;
      grant_cpu   <= 1'b0;
      grant_vid   <= 1'b0;
      grant_snd   <= 1'b0;
      grant_ref   <= 1'b0;
      we_l        <= 1'b0;
      ref_pending <= 3'd0;
    end else begin
      if (clk8_en_p) bus_phase <= bus_phase + 3'd1;
      if (boundary) begin
        video_slot <= ~video_slot;
        {grant_cpu, grant_vid, grant_snd, grant_ref} <= grant_nxt;
        if (grant_nxt[3]) we_l <= cpu_we;
      end
      ref_pending <= ref_next(ref_pending, refresh_tick, ref_take);
    end
  end

  // Strobes decode from registered state only; cpu_ack alone follows cpu_req live.
  assign cpu_ack = grant_cpu && (bus_phase >= 3'd4) && cpu_req;
  assign ram_oe  = (bus_phase >= 3'd1) && (bus_phase <= 3'd6) &&
                   (grant_vid || grant_snd || (grant_cpu && !we_l));
  assign ram_we  = (bus_phase >= 3'd2) && (bus_phase <= 3'd5) && grant_cpu && we_l;

endmodule

// File: doc/ram_slot_scheduler.md
RAM_SLOT_SCHEDULER -- requirements
Module: ram_slot_scheduler

Interface
REQ-001 SHALL provide parameter REF_MAX, default 7: saturation limit of the pending-refresh counter, range 1..7.
REQ-002 SHALL provide port: clk  input  1  system clock; all state on its rising edge.
REQ-003 SHALL provide port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port: clk8_en_p  input  1  8 MHz phase-advance enable.
REQ-005 SHALL provide port: cpu_req  input  1  CPU RAM access request, active-high (/AS asserted and RAM selected).
REQ-006 SHALL provide port: cpu_we  input  1  CPU request is a write.
REQ-007 SHALL provide port: vid_req  input  1  video fetch request.
REQ-008 SHALL provide port: snd_req  input  1  sound fetch request.
REQ-009 SHALL provide port: refresh_tick  input  1  one-clk refresh-due pulse.
REQ-010 SHALL provide port: bus_phase  output  3  current phase, 0..7.
REQ-011 SHALL provide port: video_slot  output  1  1 = current slot is a video slot, 0 = CPU slot.
REQ-012 SHALL provide ports: grant_cpu, grant_vid, grant_snd, grant_ref  output  1 each  slot owner, one-hot or all zero.
REQ-013 SHALL provide port: cpu_ack  output  1  DTACK-equivalent for the CPU, active-high.
REQ-014 SHALL provide ports: ram_oe, ram_we  output  1 each  memory read/write strobes.
REQ-015 SHALL provide port: ref_pending  output  3  pending-refresh count.

Function
REQ-016 SHALL advance bus_phase by 1 modulo 8 on each clk where clk8_en_p=1; it SHALL hold otherwise.
REQ-017 SHALL define a slot as phases 0..7; a slot boundary SHALL be a clk with clk8_en_p=1 and bus_phase=7.
REQ-018 SHALL toggle video_slot at every slot boundary, so CPU and video slots alternate.
REQ-019 SHALL register all grants only at a slot boundary and hold them unchanged for the whole following slot.
REQ-020 At a boundary into a CPU slot, arbitration priority SHALL be: cpu_req, then ref_pending>0, then no grant.
REQ-021 At a boundary into a video slot, arbitration priority SHALL be: vid_req, snd_req, ref_pending>0, cpu_req, then no grant; an unused video slot is thereby lent to the CPU.
REQ-022 SHALL latch cpu_we at the boundary that grants the CPU, into internal we_l.
REQ-023 A cpu_req rising after a boundary SHALL wait for the next boundary; no mid-slot grant.
REQ-024 cpu_ack SHALL equal grant_cpu AND bus_phase>=4 AND cpu_req; a request dropped mid-slot SHALL drop cpu_ack in the same clk, with the grant held to slot end.
REQ-025 ram_oe SHALL be 1 for phases 1..6 when grant_vid, grant_snd, or (grant_cpu AND NOT we_l) is set; 0 otherwise.
REQ-026 ram_we SHALL be 1 for phases 2..5 when grant_cpu AND we_l is set; 0 otherwise.
REQ-027 ram_oe and ram_we SHALL never both be 1, and SHALL both be 0 during grant_ref.
REQ-028 ref_pending SHALL increment on refresh_tick and saturate at REF_MAX, excess ticks being dropped.
REQ-029 ref_pending SHALL decrement by 1 at the boundary that sets grant_ref.
REQ-030 When refresh_tick coincides with a grant_ref boundary, ref_pending SHALL remain unchanged.
REQ-031 At most one refresh SHALL be granted per slot.
REQ-032 All outputs SHALL be registered or decoded only from registered state, with no combinational path from the *_req inputs except via cpu_ack.

Reset
REQ-033 While reset=1 the block SHALL hold bus_phase=0, video_slot=0, all grants=0, we_l=0, ref_pending=0, cpu_ack=0, ram_oe=0 and ram_we=0.
REQ-034 After reset release, the first slot SHALL be an idle CPU slot; the first grant SHALL appear at the first boundary, into a video slot.
REQ-035 Reset asserted mid-slot SHALL clear all state immediately, truncating any strobe in progress, with no completion of the cycle.

Verification
REQ-036 Steady cpu_req=1, cpu_we=0, vid_req=0: CPU granted every slot; cpu_ack rises at phase 4 of each slot; ram_oe high for phases 1..6.
REQ-037 vid_req=1 and cpu_req=1 continuously: grant_vid in video slots and grant_cpu in CPU slots, strictly alternating; ram_we never asserted.
REQ-038 Ten refresh_tick pulses with REF_MAX=7 and all requests idle: ref_pending saturates at 7, then drains by 1 per slot over 7 slots with grant_ref set.
REQ-039 refresh_tick coinciding with a grant_ref boundary at ref_pending=3: ref_pending stays 3.
REQ-040 cpu_req rising at phase 2 of a CPU slot with cpu_we=1: no grant until the next boundary; then grant_cpu, ram_we high for phases 2..5, cpu_ack from phase 4.
REQ-041 reset pulse at phase 5 of a CPU write slot: ram_we and cpu_ack drop immediately; after release, bus_phase=0 and video_slot=0.
